store_write_buffer: RTL and testbench

Post-retirement store buffer between the ROB retire bus and the data-memory write port. It accepts a committed store when the ROB presents `retire_store.store_ready` and acknowledges it on `store_executed`. Committed stores are held in a small circular `wc_array` queue; a retiring store to a word already buffered (and not in flight) is combined into that entry. The queue drains to memory in order with a valid/ack handshake, and buffered data is forwarded to load-address checks from the LD/ST unit.

---
 rtl/store_write_buffer_pkg.sv | 21 ++
 rtl/store_write_buffer_youngest_match.sv | 42 ++++
 rtl/store_write_buffer.sv | 145 ++++++++++++++
 tb/tb_store_write_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared types for the post-retirement store path.
//   retire_store : store handed over by the ROB retire bus
//   wc_array     : one buffered (write-combining) store entry
//   sb_state_e   : drain state of the store write buffer
package store_write_buffer_pkg;

  typedef struct packed {
    logic        store_ready;
    logic [31:0] mem_address;
    logic [31:0] retire_rs2_data;
  } retire_store;

  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic [31:0] data;
  } wc_array;

  typedef enum bit {SB_IDLE, SB_WRITE} sb_state_e;

endpackage

// File: rtl/store_write_buffer_youngest_match.sv
// sb_youngest_match: finds the youngest valid entry whose word address
// equals search_addr, walking from tail-1 back towards the oldest slot.
// Ports:
//   valid, word_addr : per-entry valid bits and address[31:2]
//   search_addr      : word address to look for
//   tail             : next allocation slot (youngest entry is tail-1)
//   exclude_en/idx   : when set, entry exclude_idx is never reported
//   hit, index       : a match exists / slot of the youngest match
module sb_youngest_match #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][29:0]   word_addr,
  input  logic [29:0]              search_addr,
  input  logic [$clog2(DEPTH)-1:0] tail,
  input  logic                     exclude_en,
  input  logic [$clog2(DEPTH)-1:0] exclude_idx,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] index
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Visit slots oldest (tail-DEPTH) to youngest (tail-1); the last match
  // written wins, which is the youngest one.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    idx   = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PTR_W'(k);
      if (valid[idx] && (word_addr[idx] == search_addr) &&
          !(exclude_en && (idx == exclude_idx))) begin
        hit   = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: holds committed stores between ROB retirement and the
// data-memory write port, combines repeat stores to a buffered word, drains
// in order and forwards buffered data to load-address checks.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   retire_st, store_executed : store from the ROB / accepted this cycle
//   mem_wr_en/addr/data/ack   : memory write request, ack pops the head
//   ld_check, ld_addr         : load lookup request
//   ld_hit, ld_data           : youngest buffered match (0 when no hit)
//   sb_full, sb_empty, sb_count : registered occupancy status
// Handshake: a memory write transfers on every cycle where mem_wr_en and
// mem_wr_ack are both high; addr/data stay stable while mem_wr_en is high
// and ack is low. A store transfers from the ROB when store_ready and
// store_executed are both high; otherwise the ROB keeps presenting it.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  retire_store       retire_st,
  output logic              store_executed,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_wr_ack,
  input  logic              ld_check,
  input  logic [31:0]       ld_addr,
  output logic              ld_hit,
  output logic [31:0]       ld_data,
  output logic              sb_full,
  output logic              sb_empty,
  output logic [CNT_W-1:0]  sb_count
);

  localparam int PTR_W = $clog2(DEPTH);

  wc_array                entry [DEPTH];
  logic [PTR_W-1:0]       head, tail;
  logic [CNT_W-1:0]       count, count_next;
  sb_state_e              state, state_next;

  logic [DEPTH-1:0]       valid_vec;
  logic [DEPTH-1:0][29:0] addr_vec;
  logic                   co_hit, fw_hit;
  logic [PTR_W-1:0]       co_idx, fw_idx;
  logic                   in_flight, coalesce, alloc, pop;

  always_comb begin
    valid_vec = '0;
    addr_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entry[i].valid;
      addr_vec[i]  = entry[i].address[31:2];
    end
  end

  // The head being written to memory must not change under the request,
  // so it is hidden from the coalesce search while in flight.
  sb_youngest_match #(.DEPTH(DEPTH)) u_coalesce_match (
    .valid       (valid_vec),
    .word_addr   (addr_vec),
    .search_addr (retire_st.mem_address[31:2]),
    .tail        (tail),
    .exclude_en  (in_flight),
    .exclude_idx (head),
    .hit         (co_hit),
    .index       (co_idx)
  );

  sb_youngest_match #(.DEPTH(DEPTH)) u_forward_match (
    .valid       (valid_vec),
    .word_addr   (addr_vec),
    .search_addr (ld_addr[31:2]),
    .tail        (tail),
    .exclude_en  (1'b0),
    .exclude_idx (head),
    .hit         (fw_hit),
    .index       (fw_idx)
  );

  always_comb begin
    in_flight      = (state == SB_WRITE);
    coalesce       = retire_st.store_ready & co_hit;
    // sb_full reflects the start-of-cycle count, so a same-cycle pop never
    // frees room for an allocate.
    alloc          = retire_st.store_ready & ~co_hit & ~sb_full;
    store_executed = retire_st.store_ready & (co_hit | ~sb_full);
    pop            = in_flight & mem_wr_ack;
    count_next     = count + {{(CNT_W-1){1'b0}}, alloc} - {{(CNT_W-1){1'b0}}, pop};

    mem_wr_en   = in_flight;
    mem_wr_addr = in_flight ? entry[head].address : 32'h0;
    mem_wr_data = in_flight ? entry[head].data    : 32'h0;

    ld_hit  = ld_check & fw_hit;
    ld_data = ld_hit ? entry[fw_idx].data : 32'h0;
  end

  always_comb begin
    state_next = state;
    case (state)
      SB_IDLE:  if ((count != '0) || alloc) state_next = SB_WRITE;
      SB_WRITE: if (pop && (count_next == '0)) state_next = SB_IDLE;
      default:  state_next = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SB_IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      sb_count <= '0;
      sb_full  <= 1'b0;
      sb_empty <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        entry[i].valid <= 1'b0;
      end
    end else begin
      state    <= state_next;
      count    <= count_next;
      sb_count <= count_next;
      sb_full  <= (count_next == CNT_W'(DEPTH));
      sb_empty <= (count_next == '0);
      if (coalesce) begin
        entry[co_idx].data <= retire_st.retire_rs2_data;
      end
      if (alloc) begin
        entry[tail].valid   <= 1'b1;
        entry[tail].address <= retire_st.mem_address;
        entry[tail].data    <= retire_st.retire_rs2_data;
        tail                <= tail + PTR_W'(1);
      end
      if (pop) begin
        entry[head].valid <= 1'b0;
        head              <= head + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer. The reference model is a queue of
// {address, data} stores in program order: retiring a store either merges
// into the youngest matching queued store other than the oldest one while
// a write is outstanding, appends when room exists, or stalls. The same
// queue is the scoreboard of expected memory writes, popped by the monitor.
module tb_store_write_buffer;
  import store_write_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  retire_store       retire_st;
  logic              store_executed;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic              mem_wr_ack;
  logic              ld_check;
  logic [31:0]       ld_addr;
  logic              ld_hit;
  logic [31:0]       ld_data;
  logic              sb_full;
  logic              sb_empty;
  logic [CNT_W-1:0]  sb_count;

  logic [63:0] exp_q[$];   // {address, data}, oldest first
  int n_vec;
  int n_err;

  store_write_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .retire_st      (retire_st),
    .store_executed (store_executed),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_ack     (mem_wr_ack),
    .ld_check       (ld_check),
    .ld_addr        (ld_addr),
    .ld_hit         (ld_hit),
    .ld_data        (ld_data),
    .sb_full        (sb_full),
    .sb_empty       (sb_empty),
    .sb_count       (sb_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endfunction

  // ---------------- driver ----------------
  // One cycle: inputs change on the falling edge, outputs are checked 1ns
  // later, and the model applies this cycle's store.
  task automatic drive(input logic r, input logic sr, input logic [31:0] a,
                       input logic [31:0] d, input logic ak,
                       input logic lc, input logic [31:0] la);
    int          size0;
    int          fw_j;
    int          co_j;
    logic        exp_hit;
    logic [31:0] exp_ld;
    logic        exp_se;
    logic [63:0] tmp;
    @(negedge clk);
    rst                       = r;
    retire_st.store_ready     = sr & ~r;
    retire_st.mem_address     = a;
    retire_st.retire_rs2_data = d;
    mem_wr_ack                = ak;
    ld_check                  = lc;
    ld_addr                   = la;
    #1;
    if (r) begin
      exp_q.delete();
    end else begin
      size0 = exp_q.size();
      chk("sb_count", 32'(sb_count), 32'(size0));
      chk("sb_full",  32'(sb_full),  32'(size0 == DEPTH));
      chk("sb_empty", 32'(sb_empty), 32'(size0 == 0));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(size0 > 0));
      if (size0 > 0) begin
        chk("mem_wr_addr", mem_wr_addr, exp_q[0][63:32]);
        chk("mem_wr_data", mem_wr_data, exp_q[0][31:0]);
      end else begin
        chk("idle_addr", mem_wr_addr, 32'h0);
        chk("idle_data", mem_wr_data, 32'h0);
      end
      // Load forward: youngest queued store to the same word.
      fw_j = -1;
      for (int j = size0 - 1; j >= 0 && fw_j < 0; j--)
        if (exp_q[j][63:34] == la[31:2]) fw_j = j;
      exp_hit = lc && (fw_j >= 0);
      exp_ld  = exp_hit ? exp_q[fw_j][31:0] : 32'h0;
      chk("ld_hit",  32'(ld_hit), 32'(exp_hit));
      chk("ld_data", ld_data, exp_ld);
      // A non-empty buffer always has its oldest store in flight.
      co_j = -1;
      for (int j = size0 - 1; j >= 1 && co_j < 0; j--)
        if (exp_q[j][63:34] == a[31:2]) co_j = j;
      exp_se = sr && ((co_j >= 0) || (size0 < DEPTH));
      chk("store_executed", 32'(store_executed), 32'(exp_se));
      if (sr && co_j >= 0) begin
        tmp        = exp_q[co_j];
        tmp[31:0]  = d;
        exp_q[co_j] = tmp;
      end else if (sr && size0 < DEPTH) begin
        exp_q.push_back({a, d});
      end
    end
  endtask

  task automatic idle(input logic ak, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, ak, 1'b0, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic ak);
    drive(1'b0, 1'b1, a, d, ak, 1'b0, 32'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && mem_wr_en && mem_wr_ack) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", 32'(mem_wr_en), 32'h0);
        end else begin
          chk("write_addr", mem_wr_addr, exp_q[0][63:32]);
          chk("write_data", mem_wr_data, exp_q[0][31:0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    retire_st = '0;
    mem_wr_ack = 1'b0;
    ld_check = 1'b0;
    ld_addr = 32'h0;

    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(1'b0, 2);                                  // reset state

    // Single store into an empty buffer, ack tied high.
    store(32'h100, 32'hDEADBEEF, 1'b1);
    idle(1'b1, 3);

    // Fill and stall.
    store(32'h010, 32'h11, 1'b0);
    store(32'h014, 32'h22, 1'b0);
    store(32'h018, 32'h33, 1'b0);
    store(32'h01C, 32'h44, 1'b0);
    store(32'h200, 32'h55, 1'b0);                   // full: stalls
    store(32'h200, 32'h55, 1'b1);                   // pop cycle: still stalls
    store(32'h200, 32'h55, 1'b0);                   // accepted now
    idle(1'b1, 6);

    // Coalesce behind an in-flight head; head itself is never merged.
    store(32'h100, 32'h1, 1'b0);
    store(32'h104, 32'h2, 1'b0);
    store(32'h104, 32'h5, 1'b0);
    store(32'h100, 32'h7, 1'b0);
    idle(1'b1, 5);

    // Forward.
    store(32'h300, 32'hA, 1'b0);
    store(32'h304, 32'hB, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h302);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h400);
    drive(1'b0, 1'b1, 32'h308, 32'hC, 1'b0, 1'b1, 32'h308); // same-cycle store not forwarded
    idle(1'b1, 5);

    // Wrap-around: ten store/ack pairs.
    for (int i = 0; i < 10; i++) store(32'h500 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1);
    idle(1'b1, 6);

    // Reset in the middle of a write.
    store(32'h600, 32'h61, 1'b0);
    store(32'h604, 32'h62, 1'b0);
    store(32'h608, 32'h63, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(1'b1, 4);

    // Random traffic over a small address pool to exercise merging.
    for (int i = 0; i < 400; i++) begin
      ra = {26'h0, 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      drive(1'b0, 1'($urandom_range(0, 1)), ra, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            {26'h0, 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))});
    end

    idle(1'b1, 8);
    chk("drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
